// File: rtl/qupls_bitdep_pkg.sv
// qupls_bitdep_pkg: shared types for the bit scatter/gather unit.
package qupls_bitdep_pkg;
  typedef logic [127:0] value_t;
  typedef logic [5:0] rob_ndx_t;
  typedef enum logic [0:0] {BD_PEXT = 1'b0, BD_PDEP = 1'b1} bitdep_op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} bitdep_state_t;
endpackage

// File: rtl/qupls_bitdep_slice.sv
// qupls_bitdep_slice: one cycle of PEXT/PDEP over BPC mask bits starting at pos.
module qupls_bitdep_slice #(
  parameter int WID = 128,
  parameter int BPC = 8,
  localparam int PW = $clog2(WID),
  localparam int KW = PW + 1
) (
  input  logic           pdep,
  input  logic [BPC-1:0] msk,
  input  logic [WID-1:0] a,
  input  logic [PW-1:0]  pos,
  input  logic [WID-1:0] res,
  input  logic [KW-1:0]  k,
  output logic [WID-1:0] res_o,
  output logic [KW-1:0]  k_o
);
  logic [WID-1:0] r;
  logic [KW-1:0] kk;
  logic [PW-1:0] idx;
  always_comb begin
    r = res;
    kk = k;
    idx = pos;
    for (int j = 0; j < BPC; j++) begin
      idx = pos + PW'(j);
      if (msk[j]) begin
        if (pdep) r[idx] = a[kk[PW-1:0]];
        else r[kk[PW-1:0]] = a[idx];
        kk = kk + 1'b1;
      end
    end
    res_o = r;
    k_o = kk;
  end
endmodule

// File: rtl/qupls_bitdep.sv
// qupls_bitdep: iterative PEXT/PDEP unit with fixed WID/BPC+1 cycle latency.
module qupls_bitdep
  import qupls_bitdep_pkg::*;
#(
  parameter int WID = 128,
  parameter int BPC = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  bitdep_op_t     op,
  input  logic [WID-1:0] a,
  input  logic [WID-1:0] b,
  input  rob_ndx_t       rob_i,
  output logic           idle_o,
  output logic           done,
  output logic [WID-1:0] o,
  output rob_ndx_t       rob_o
);
  localparam int PW = $clog2(WID);
  localparam int KW = PW + 1;
  bitdep_state_t st, st_n;
  bitdep_op_t op_r;
  logic [WID-1:0] a_r, b_r, res, res_n;
  rob_ndx_t tag_r;
  logic [PW-1:0] pos;
  logic [KW-1:0] k, k_n;
  logic acc, last;
  assign acc = ld && st != RUN;
  assign last = pos == PW'(WID - BPC);
  assign idle_o = st != RUN;
  assign done = st == DONE;
  always_comb st_n = st == RUN ? (last ? DONE : RUN) : (acc ? RUN : IDLE);
  qupls_bitdep_slice #(.WID(WID), .BPC(BPC)) u_slice (
    .pdep(op_r == BD_PDEP),
    .msk(b_r[pos +: BPC]),
    .a(a_r),
    .pos(pos),
    .res(res),
    .k(k),
    .res_o(res_n),
    .k_o(k_n)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      op_r <= BD_PEXT;
      a_r <= '0;
      b_r <= '0;
      tag_r <= '0;
      res <= '0;
      pos <= '0;
      k <= '0;
      o <= '0;
      rob_o <= '0;
    end else begin
      st <= st_n;
      if (acc) begin
        op_r <= op;
        a_r <= a;
        b_r <= b;
        tag_r <= rob_i;
        res <= '0;
        pos <= '0;
        k <= '0;
      end else if (st == RUN) begin
        res <= res_n;
        k <= k_n;
        pos <= pos + PW'(BPC);
        if (last) begin
          o <= res_n;
          rob_o <= tag_r;
        end
      end
    end
  end
endmodule

// File: tb/tb_qupls_bitdep.sv
// tb_qupls_bitdep: random and directed PEXT/PDEP checks against a software model.
module tb_qupls_bitdep;
  import qupls_bitdep_pkg::*;
  logic clk = 0, rst = 1, ld = 0;
  bitdep_op_t op = BD_PEXT;
  logic [127:0] a = '0, b = '0;
  rob_ndx_t rob_i = '0;
  logic idle_o, done;
  logic [127:0] o;
  rob_ndx_t rob_o;
  typedef struct {int due; logic [127:0] res; rob_ndx_t rob;} exp_t;
  exp_t q[$];
  int cyc = 0, acc_c = 0, errs = 0, nchk = 0;
  bit have = 0;
  logic [127:0] cur_o = '0;
  rob_ndx_t cur_rob = '0;

  qupls_bitdep dut (.clk(clk), .rst(rst), .ld(ld), .op(op), .a(a), .b(b), .rob_i(rob_i),
                    .idle_o(idle_o), .done(done), .o(o), .rob_o(rob_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] model(bitdep_op_t f, logic [127:0] x, logic [127:0] m);
    logic [127:0] r = '0;
    int n = 0;
    for (int i = 0; i < 128; i++)
      if (m[i]) begin
        if (f == BD_PDEP) r[i] = x[n];
        else r[n] = x[i];
        n++;
      end
    return r;
  endfunction

  function automatic bit model_idle();
    return !(have && cyc >= acc_c + 1 && cyc <= acc_c + 16);
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("idle_o", 128'(idle_o), 128'(model_idle()));
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("done", 128'(done), 128'd1);
        chk("o", o, q[0].res);
        chk("rob_o", 128'(rob_o), 128'(q[0].rob));
        cur_o = q[0].res;
        cur_rob = q[0].rob;
        void'(q.pop_front());
      end else begin
        chk("no_done", 128'(done), 128'd0);
        chk("o_hold", o, cur_o);
        chk("rob_hold", 128'(rob_o), 128'(cur_rob));
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that samples ld.
  task automatic send(bitdep_op_t f, logic [127:0] x, logic [127:0] m, rob_ndx_t t);
    op = f; a = x; b = m; rob_i = t; ld = 1;
    if (model_idle()) begin
      have = 1;
      acc_c = cyc;
      q.push_back('{cyc + 17, model(f, x, m), t});
    end
    @(posedge clk); #1;
    ld = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    q.delete();
    have = 0;
    cur_o = '0;
    cur_rob = '0;
    chk("rst_idle", 128'(idle_o), 128'd1);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_o", o, 128'd0);
    chk("rst_rob", 128'(rob_o), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Runs one op to its DONE cycle and pins the result to a hand-computed value.
  task automatic lit(string name, bitdep_op_t f, logic [127:0] x, logic [127:0] m, rob_ndx_t t,
                     logic [127:0] exp);
    send(f, x, m, t);
    repeat (16) @(posedge clk);
    #1;
    chk({name, "_done"}, 128'(done), 128'd1);
    chk(name, o, exp);
    chk({name, "_rob"}, 128'(rob_o), 128'(t));
  endtask

  initial begin
    logic [127:0] big, r1;
    do_reset();
    @(posedge clk); #1;
    lit("pext_f0", BD_PEXT, 128'hF0F0, 128'hFF00, 6'd5, 128'hF0);
    lit("pdep_50", BD_PDEP, 128'h5, 128'hF0, 6'd1, 128'h50);
    lit("pdep_top", BD_PDEP, 128'h1, 128'h1 << 127, 6'd2, 128'h1 << 127);
    lit("pext_top", BD_PEXT, 128'h1 << 127, 128'h1 << 127, 6'd3, 128'h1);
    lit("pext_b0", BD_PEXT, '1, '0, 6'd4, '0);
    lit("pdep_b0", BD_PDEP, '1, '0, 6'd6, '0);
    big = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    lit("pext_all", BD_PEXT, big, '1, 6'd7, big);
    lit("pdep_all", BD_PDEP, big, '1, 6'd8, big);
    @(posedge clk); #1;
    // ld mid-run is ignored, ld in DONE is accepted
    send(BD_PEXT, 128'hABCD, 128'h0F0F, 6'd9);
    repeat (3) @(posedge clk); #1;
    send(BD_PDEP, '1, '1, 6'd10);
    repeat (12) @(posedge clk); #1;
    chk("ign_done", 128'(done), 128'd1);
    chk("ign_o", o, 128'hBD);
    send(BD_PDEP, 128'h3, 128'h8001, 6'd11);
    repeat (16) @(posedge clk); #1;
    chk("b2b_o", o, 128'h8001);
    chk("b2b_rob", 128'(rob_o), 128'd11);
    repeat (2) @(posedge clk); #1;
    // reset mid-run: no done pulse, next op completes
    send(BD_PEXT, '1, '1, 6'd12);
    repeat (7) @(posedge clk); #1;
    do_reset();
    repeat (20) @(posedge clk); #1;
    lit("post_rst", BD_PEXT, 128'hF0F0, 128'hFF00, 6'd13, 128'hF0);
    for (int i = 0; i < 1000; i++) begin
      r1 = {$urandom, $urandom, $urandom, $urandom};
      big = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0: big = big & {$urandom, $urandom, $urandom, $urandom};
        1: big = big | {$urandom, $urandom, $urandom, $urandom};
        default: ;
      endcase
      send(bitdep_op_t'($urandom_range(0, 1)), r1, big, rob_ndx_t'($urandom_range(0, 63)));
      repeat (16) @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    repeat (20) @(posedge clk); #1;
    chk("drained", 128'(q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
